// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// sensor_debounce : 3-channel synchronise + debounce with sticky chatter flags
// Revision 1.0
// ============================================================================
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CHATTER_LIMIT   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_c,
  input  logic clear_chatter,
  output logic sensor_a,
  output logic sensor_b,
  output logic sensor_c,
  output logic chatter_a,
  output logic chatter_b,
  output logic chatter_c,
  output logic chatter_any
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BNC_W = $clog2(CHATTER_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BNC_W-1:0] C_BNC_MAX  = BNC_W'(CHATTER_LIMIT);

  logic [2:0] raw_vec;
  logic [2:0] sensor_vec;
  logic [2:0] chatter_vec;
  logic [2:0] chatter_nxt;
  logic       chatter_any_q;
  logic       chatter_any_d;

  assign raw_vec = {raw_c, raw_b, raw_a};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sensor_q, sensor_d;
    logic             chatter_q, chatter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BNC_W-1:0] bounce_q, bounce_d;
    logic             abort;
    logic             set_flag;

    always_comb begin
      sync1_d   = raw_vec[i];
      sync2_d   = sync1_q;
      sensor_d  = sensor_q;
      cnt_d     = '0;
      bounce_d  = bounce_q;
      chatter_d = chatter_q;
      abort     = 1'b0;
      set_flag  = 1'b0;

      if (sync2_q != sensor_q) begin
        if (cnt_q == C_CNT_LAST) begin
          sensor_d = sync2_q;
          bounce_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        abort = (cnt_q != '0);
      end

      if (abort) begin
        if (bounce_q != C_BNC_MAX) begin
          bounce_d = bounce_q + 1'b1;
        end
        set_flag = (bounce_d == C_BNC_MAX);
      end

      // A flag being set on this edge outranks a simultaneous clear.
      if (set_flag) begin
        chatter_d = 1'b1;
      end else if (clear_chatter) begin
        chatter_d = 1'b0;
        bounce_d  = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        sensor_q  <= 1'b0;
        chatter_q <= 1'b0;
        cnt_q     <= '0;
        bounce_q  <= '0;
      end else begin
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
        sensor_q  <= sensor_d;
        chatter_q <= chatter_d;
        cnt_q     <= cnt_d;
        bounce_q  <= bounce_d;
      end
    end

    assign sensor_vec[i]  = sensor_q;
    assign chatter_vec[i] = chatter_q;
    assign chatter_nxt[i] = chatter_d;
  end

  always_comb begin
    chatter_any_d = |chatter_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chatter_any_q <= 1'b0;
    end else begin
      chatter_any_q <= chatter_any_d;
    end
  end

  assign sensor_a    = sensor_vec[0];
  assign sensor_b    = sensor_vec[1];
  assign sensor_c    = sensor_vec[2];
  assign chatter_a   = chatter_vec[0];
  assign chatter_b   = chatter_vec[1];
  assign chatter_c   = chatter_vec[2];
  assign chatter_any = chatter_any_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_debounce.sv
`default_nettype none
// ============================================================================
// tb_sensor_debounce : vector table, corner-case sequences, randomized model check
// Revision 1.0
// ============================================================================
module tb_sensor_debounce;

  localparam int DEB = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic raw_a, raw_b, raw_c;
  logic clear_chatter;
  logic sensor_a, sensor_b, sensor_c;
  logic chatter_a, chatter_b, chatter_c;
  logic chatter_any;

  int checks = 0;
  int errors = 0;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .CHATTER_LIMIT  (LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_a        (raw_a),
    .raw_b        (raw_b),
    .raw_c        (raw_c),
    .clear_chatter(clear_chatter),
    .sensor_a     (sensor_a),
    .sensor_b     (sensor_b),
    .sensor_c     (sensor_c),
    .chatter_a    (chatter_a),
    .chatter_b    (chatter_b),
    .chatter_c    (chatter_c),
    .chatter_any  (chatter_any)
  );

  always #5 clk = ~clk;

  // Output vector layout: {chatter_any, chatter_c/b/a, sensor_c/b/a}
  function automatic logic [6:0] outs();
    return {chatter_any, chatter_c, chatter_b, chatter_a, sensor_c, sensor_b, sensor_a};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] raw, input logic clr);
    rst = r;
    {raw_c, raw_b, raw_a} = raw;
    clear_chatter = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a channel's output flips once the last DEB synchronised
  // samples taken since its previous flip all disagree with it; an abort is a
  // sample agreeing with the output right after one that disagreed.
  logic [2:0] raw_v;
  assign raw_v = {raw_c, raw_b, raw_a};

  bit m_s1   [3];
  bit m_s2   [3];
  bit m_sens [3];
  bit m_chat [3];
  bit m_any;
  int m_nsamp[3];
  int m_abort[3];
  bit m_win  [3][DEB];
  bit m_s, m_flip, m_ab, m_set, m_diff;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_sens[c] = 0; m_chat[c] = 0;
        m_nsamp[c] = 0; m_abort[c] = 0;
        for (int k = 0; k < DEB; k++) m_win[c][k] = 0;
      end
      m_any = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_s = m_s2[c];
        for (int k = DEB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
        m_win[c][0] = m_s;
        if (m_nsamp[c] < DEB) m_nsamp[c]++;
        m_diff = 1;
        for (int k = 0; k < DEB; k++) if (m_win[c][k] == m_sens[c]) m_diff = 0;
        m_flip = (m_nsamp[c] == DEB) && m_diff;
        m_ab   = (m_nsamp[c] >= 2) && (m_win[c][0] == m_sens[c]) && (m_win[c][1] != m_sens[c]);
        m_set  = 0;
        if (m_flip) begin
          m_sens[c]  = m_s;
          m_nsamp[c] = 0;
          m_abort[c] = 0;
        end
        if (m_ab) begin
          m_abort[c] = (m_abort[c] + 1 > LIM) ? LIM : m_abort[c] + 1;
          m_set = (m_abort[c] == LIM);
        end
        if (m_set) m_chat[c] = 1;
        else if (clear_chatter) begin
          m_chat[c]  = 0;
          m_abort[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_v[c];
      end
      m_any = m_chat[0] | m_chat[1] | m_chat[2];
    end
  end

  typedef struct {
    logic       r;
    logic [2:0] raw;
    logic       clr;
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  // 3 high / 3 low bursts on one channel; the 4th abort lands on the last low edge.
  task automatic chatter_burst(input int ch, input bit clr_last);
    logic [2:0] pulse;
    logic [6:0] o;
    pulse = 3'b001 << ch;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        drive(1'b0, pulse, 1'b0);
        tick();
        o = outs();
        chk("burst_sensor_hi", {6'b0, o[ch]}, 7'b0);
      end
      for (int j = 0; j < 3; j++) begin
        drive(1'b0, 3'b000, clr_last && (k == 3) && (j == 2));
        tick();
        o = outs();
        chk("burst_sensor_lo", {6'b0, o[ch]}, 7'b0);
        if (j == 2) chk("burst_flag_any", {5'b0, o[3+ch], o[6]}, {5'b0, (k == 3), (k == 3)});
      end
    end
    drive(1'b0, 3'b000, 1'b0);
  endtask

  initial begin : main
    logic [6:0] o;
    logic [6:0] exp;
    int pct;
    logic [2:0] lvl;
    logic r_rand, c_rand;

    // Reset, then all three rise together; clean falls/rises on b; all fall.
    tbl.push_back('{1'b1, 3'b111, 1'b0, 3, 7'b0000000});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 9, 7'b0000000});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 1, 7'b0000111});
    tbl.push_back('{1'b0, 3'b101, 1'b0, 9, 7'b0000111});
    tbl.push_back('{1'b0, 3'b101, 1'b0, 1, 7'b0000101});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 9, 7'b0000101});
    tbl.push_back('{1'b0, 3'b111, 1'b0, 1, 7'b0000111});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 9, 7'b0000111});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 1, 7'b0000000});
    // Four 5-cycle pulses on c: each rejected, the 4th abort sets chatter_c.
    for (int k = 1; k <= 4; k++) begin
      exp = (k == 4) ? 7'b1100000 : 7'b0000000;
      tbl.push_back('{1'b0, 3'b100, 1'b0, 5, 7'b0000000});
      tbl.push_back('{1'b0, 3'b000, 1'b0, 2, 7'b0000000});
      tbl.push_back('{1'b0, 3'b000, 1'b0, 1, exp});
      tbl.push_back('{1'b0, 3'b000, 1'b0, 2, exp});
    end
    tbl.push_back('{1'b0, 3'b000, 1'b1, 1, 7'b0000000});
    tbl.push_back('{1'b0, 3'b000, 1'b0, 2, 7'b0000000});

    drive(1'b1, 3'b000, 1'b0);
    foreach (tbl[i]) begin
      for (int t = 0; t < tbl[i].n; t++) begin
        drive(tbl[i].r, tbl[i].raw, tbl[i].clr);
        tick();
        chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end
    end

    // Chatter on a; flag survives a later settled rise.
    chatter_burst(0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      drive(1'b0, 3'b001, 1'b0);
      tick();
      o = outs();
      chk("settle_after_chatter", {4'b0, o[6], o[3], o[0]}, {4'b0, 1'b1, 1'b1, (t == 10)});
    end
    drive(1'b0, 3'b000, 1'b1);
    tick();
    chk("clear_a", outs(), 7'b0000001);
    for (int t = 1; t <= 10; t++) begin
      drive(1'b0, 3'b000, 1'b0);
      tick();
    end
    chk("a_fall", outs(), 7'b0000000);

    // Clear collides with the 4th abort on b: set wins; a lone clear then clears.
    chatter_burst(1, 1'b1);
    drive(1'b0, 3'b000, 1'b1);
    tick();
    chk("clear_b_alone", outs(), 7'b0000000);
    drive(1'b0, 3'b000, 1'b0);

    // Reset at debounce count 5 of a rise on a, then re-qualification.
    for (int t = 0; t < 7; t++) begin
      drive(1'b0, 3'b001, 1'b0);
      tick();
      chk("midcnt_pre", outs(), 7'b0000000);
    end
    drive(1'b1, 3'b001, 1'b0);
    tick();
    chk("midcnt_rst", outs(), 7'b0000000);
    for (int t = 1; t <= 10; t++) begin
      drive(1'b0, 3'b001, 1'b0);
      tick();
      chk("midcnt_requal", outs(), {6'b0, (t == 10)});
    end
    for (int t = 0; t < 10; t++) begin
      drive(1'b0, 3'b000, 1'b0);
      tick();
    end
    chk("midcnt_fall", outs(), 7'b0000000);

    // Randomized phase against the reference model.
    lvl = 3'b000;
    pct = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(2))
          0: pct = 2;
          1: pct = 12;
          default: pct = 35;
        endcase
      end
      for (int c = 0; c < 3; c++) if ($urandom_range(99) < pct) lvl[c] = ~lvl[c];
      c_rand = ($urandom_range(63) == 0);
      r_rand = ($urandom_range(499) == 0);
      drive(r_rand, lvl, c_rand);
      tick();
      chk("random_vs_model", outs(),
          {m_any, m_chat[2], m_chat[1], m_chat[0], m_sens[2], m_sens[1], m_sens[0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
